// File: rtl/fp_add_seq_if.sv
// Start/done handshake bundle for the sequential binary32 adder.
interface fp_add_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, a, b, sub, input busy, done, result);
  modport slave  (input start, a, b, sub, output busy, done, result);
endinterface

// File: rtl/fp_add_seq.sv
// Four-cycle binary32 add/subtract with flush-to-zero denormals.
// FP_ADD_RNE_EN selects round-to-nearest-even; default build truncates.
module fp_add_seq (
  input  logic       clk,
  input  logic       rst,
  fp_add_seq_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start, result held
  // ALIGN | unpack, swap, align smaller operand, detect specials
  // ADD   | add or subtract aligned mantissas
  // NORM  | normalise sum, adjust exponent
  // ROUND | round, range check, write result
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

  state_t             state;
  logic [31:0]        a_q, b_q;
  logic               sign_q, eff_sub_q, zero_q, special_q;
  logic signed [9:0]  exp_q;
  logic [26:0]        mx_q, my_q, mant_q;
  logic [27:0]        sum_q;
  logic [31:0]        special_val_q;

  logic        za, zb, nan_a, nan_b, inf_a, inf_b, swap;
  logic [30:0] mag_a, mag_b;
  logic [23:0] ma, mb, mx, my;
  logic [7:0]  ex, ey, diff;
  logic [4:0]  sh;
  logic [53:0] wide;
  logic [26:0] y_al;
  logic        spec;
  logic [31:0] spec_val;

  assign za    = (a_q[30:23] == 8'd0);
  assign zb    = (b_q[30:23] == 8'd0);
  assign nan_a = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign nan_b = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
  assign inf_a = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign inf_b = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
  assign ma    = za ? 24'd0 : {1'b1, a_q[22:0]};
  assign mb    = zb ? 24'd0 : {1'b1, b_q[22:0]};
  assign mag_a = za ? 31'd0 : a_q[30:0];
  assign mag_b = zb ? 31'd0 : b_q[30:0];
  assign swap  = (mag_b > mag_a);
  assign ex    = swap ? b_q[30:23] : a_q[30:23];
  assign ey    = swap ? (za ? 8'd0 : a_q[30:23]) : (zb ? 8'd0 : b_q[30:23]);
  assign mx    = swap ? mb : ma;
  assign my    = swap ? ma : mb;
  assign diff  = ex - ey;
  assign sh    = (diff >= 8'd27) ? 5'd27 : diff[4:0];
  // Everything that falls below the sticky position is ORed back into it.
  assign wide  = {my, 30'd0} >> sh;
  assign y_al  = {wide[53:28], wide[27] | (|wide[26:0])};

  always_comb begin
    spec     = 1'b1;
    spec_val = 32'd0;
    if (nan_a || nan_b || (inf_a && inf_b && (a_q[31] != b_q[31])))
      spec_val = 32'h7FC00000;
    else if (inf_a)
      spec_val = {a_q[31], 8'hFF, 23'd0};
    else if (inf_b)
      spec_val = {b_q[31], 8'hFF, 23'd0};
    else if (za && zb)
      spec_val = {a_q[31] & b_q[31], 31'd0};
    else
      spec = 1'b0;
  end

  logic [4:0] lz;
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum_q[i]) lz = 5'(26 - i);
  end

  logic               rnd_inc;
  logic [24:0]        m25;
  logic signed [9:0]  exp_rnd;
  logic [22:0]        frac;
`ifdef FP_ADD_RNE_EN
  assign rnd_inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
`else
  assign rnd_inc = 1'b0;
`endif
  assign m25     = {1'b0, mant_q[26:3]} + {24'd0, rnd_inc};
  assign exp_rnd = exp_q + $signed({9'd0, m25[24]});
  assign frac    = m25[24] ? m25[23:1] : m25[22:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= 32'd0;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      sign_q        <= 1'b0;
      eff_sub_q     <= 1'b0;
      zero_q        <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= 32'd0;
      exp_q         <= 10'sd0;
      mx_q          <= 27'd0;
      my_q          <= 27'd0;
      mant_q        <= 27'd0;
      sum_q         <= 28'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= {bus.b[31] ^ bus.sub, bus.b[30:0]};
            bus.busy <= 1'b1;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          sign_q        <= swap ? b_q[31] : a_q[31];
          eff_sub_q     <= a_q[31] ^ b_q[31];
          exp_q         <= $signed({2'b00, ex});
          mx_q          <= {mx, 3'b000};
          my_q          <= y_al;
          special_q     <= spec;
          special_val_q <= spec_val;
          state         <= ADD;
        end
        ADD: begin
          sum_q <= eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                             : ({1'b0, mx_q} + {1'b0, my_q});
          state <= NORM;
        end
        NORM: begin
          zero_q <= (sum_q == 28'd0);
          if (sum_q[27]) begin
            mant_q <= {sum_q[27:2], sum_q[1] | sum_q[0]};
            exp_q  <= exp_q + 10'sd1;
          end else begin
            mant_q <= sum_q[26:0] << lz;
            exp_q  <= exp_q - $signed({5'd0, lz});
          end
          state <= ROUND;
        end
        ROUND: begin
          if (special_q)
            bus.result <= special_val_q;
          else if (zero_q)
            bus.result <= 32'd0;
          else if (exp_rnd >= 10'sd255)
            bus.result <= {sign_q, 8'hFF, 23'd0};
          else if (exp_rnd <= 10'sd0)
            bus.result <= {sign_q, 31'd0};
          else
            bus.result <= {sign_q, exp_rnd[7:0], frac};
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
